// File: rtl/nibble_serial_sub.sv
// Nibble-serial multi-word subtractor: diff = a - b - bin, one 4-bit slice per cycle, LSB first.
// Optional NIBBLE_SUB_OVF_EN adds a registered two's-complement overflow output (ovf).
module nibble_serial_sub #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout,
`ifdef NIBBLE_SUB_OVF_EN
  output logic                 ovf,
`endif
  output logic                 busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic [4:0]    sub;
`ifdef NIBBLE_SUB_OVF_EN
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          ovf_q, ovf_d;
`endif

  // Operands shift right so the active slice always sits in bits [3:0].
  assign sub = {1'b0, a_sh_q[3:0]} - {1'b0, b_sh_q[3:0]} - {4'b0000, borrow_q};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef NIBBLE_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
`ifdef NIBBLE_SUB_OVF_EN
          a_msb_d  = a[W-1];
          b_msb_d  = b[W-1];
`endif
        end
      end
      RUN: begin
        diff_d[{idx_q, 2'b00} +: 4] = sub[3:0];
        borrow_d = sub[4];
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        if (idx_q == LAST) begin
          bout_d  = sub[4];
          idx_d   = '0;
          state_d = DONE;
`ifdef NIBBLE_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (sub[3] != a_msb_q);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef NIBBLE_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef NIBBLE_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef NIBBLE_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-word subtractor that computes a - b - bin for operands of NIBBLES*4 bits.
- Processes one 4-bit slice per cycle, LSB nibble first, and chains the borrow between slices in a register.
- Sits upstream of the 4-bit subtract datapath as its sequencer. It also serves as the standalone wide-subtract stage.
- Valid/ready handshake on both input and output sides.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and bin are valid
- in_ready  output  1  block can accept an operation
- a  input  W  minuend
- b  input  W  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- diff  output  W  result a - b - bin, modulo 2^W
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned)
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset is synchronous and active-high. On a rising clk edge with rst=1, the following are cleared:
  - state to IDLE, nibble index to 0, borrow register to 0
  - diff=0, bout=0, out_valid=0, in_ready=1, busy=0
- rst overrides all other inputs, including an operation in flight, which is aborted with no output.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block captures a and b into shift registers and bin into the borrow register, clears the index, and moves to RUN.
  - Changes to a, b or bin after capture have no effect.
- RUN:
  - in_ready=0.
  - Each edge processes slice i: {br, d} = a_i - b_i - borrow, using a 5-bit subtract. a_i and b_i are nibble i, and br is 1 when the true result is negative.
  - d is written to diff[4i+3:4i], borrow is set to br, and i increments.
  - On the edge that processes slice NIBBLES-1: bout = br, out_valid=1, state moves to DONE.
  - out_valid therefore rises on the NIBBLES-th edge after the accepting edge. No result is produced early.
- DONE:
  - diff and bout are held stable while out_valid=1 and out_ready=0, with no limit on how long the hold lasts.
  - On an edge with out_ready=1: out_valid=0, state moves to IDLE. diff and bout keep their last values.
  - in_ready stays 0 in DONE. The next operation is accepted no earlier than the edge after the handshake completes.
- Throughput: one operation per NIBBLES+2 cycles when both sides are always ready.
- NIBBLES=1: RUN lasts one edge, and the block behaves as a registered 4-bit subtractor with borrow-in.
- Wrap-around:
  - diff is modulo 2^W.
  - a=0, b=0, bin=1 gives diff=all ones, bout=1.
  - a=all ones, b=all ones, bin=1 gives diff=all ones, bout=1.
- in_valid while busy is ignored and no data is lost. The producer must hold in_valid until in_ready=1.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: NIBBLE_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow flag.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), evaluated on the captured operands and the final diff.
  - ovf is registered alongside bout in the same edge and held in DONE.
  - ovf resets to 0.
- When undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- Basic subtract, NIBBLES=4, rst pulse: a=16'h1234, b=16'h0235, bin=0 -> diff=16'h0FFF, bout=0. out_valid rises 4 edges after accept.
- Underflow: a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1.
- Borrow-in chain: a=16'h1000, b=16'h0FFF, bin=1 -> diff=16'h0000, bout=0. This exercises borrow propagation through all 4 slices.
- Backpressure: after the first result, hold out_ready=0 for 7 cycles with in_valid=1 and new operands applied.
  - Required: diff, bout and out_valid stable; in_ready=0; new operands not captured.
  - Then out_ready=1: in_ready=1 on the next cycle, and the queued op is accepted.
- Reset mid-op: assert rst on the 2nd RUN edge -> next cycle diff=0, bout=0, out_valid=0, in_ready=1, busy=0. A fresh op of 16'h0005 - 16'h0003 then gives diff=16'h0002.
- With NIBBLE_SUB_OVF_EN defined:
  - a=16'h7FFF, b=16'h8000, bin=0 -> diff=16'hFFFF, ovf=1, bout=1.
  - a=16'h0000, b=16'h8000, bin=1 -> diff=16'h7FFF, ovf=0.
